mux2_4b_gate: RTL and testbench
===============================

Name: mux2_4b_gate

Overview:
- 4-bit, 2-to-1 multiplexer built from explicit gate-level primitives (AND/OR/NOT), with no behavioural `?:` or `if` on the datapath.
- Used as a leaf datapath-select element in the ECE2300-style processor/datapath labs.
- The primary output `out` is purely combinational.
- A registered copy `out_q` is provided for pipelined consumers; it runs on the single block clock with an asynchronous active-low reset.

Parameters:
- NBITS, 4: datapath width. Only 4 is required to be verified. Generic replication must work for any NBITS ≥ 1.

Ports:
- clk    input   1      block clock; rising-edge active.
- reset  input   1      reset; asynchronous, active-low (0 = in reset).
- in0    input   NBITS  data input selected when sel = 0.
- in1    input   NBITS  data input selected when sel = 1.
- sel    input   1      select line.
- out    output  NBITS  combinational mux result.
- out_q  output  NBITS  out registered on the rising clk edge.

Behaviour:
- Per bit i: out[i] = (in0[i] & in1[i]) | (~sel & in0[i]) | (sel & in1[i]).
  - The consensus term (in0 & in1) is mandatory.
  - With it, out stays glitch-free when sel toggles while in0[i] = in1[i] = 1.
- Functional result:
  - sel = 0 → out = in0.
  - sel = 1 → out = in1.
  - The unselected input has no effect on out.
- out has zero-cycle latency. It depends on in0, in1 and sel only; clk and reset do not affect it.
- out must settle well within one clock period. The bench applies inputs, then samples 8 time units later in a 10-unit cycle.
- Gate-level only:
  - A single inverter generates ~sel, shared across all bits.
  - Each bit uses three 2-input AND gates and one 3-input OR gate (or two 2-input ORs).
- out_q:
  - reset low → out_q = 0 immediately, without waiting for a clock edge.
  - While reset is low, out_q holds 0 regardless of clk.
  - First rising edge after reset deasserts → out_q takes the current out.
  - Afterwards, out_q = out as sampled at each rising clk edge; latency is 1 cycle.
- Reset asserted mid-operation clears out_q at once. out continues to follow its inputs.
- X/Z handling:
  - When sel = X and in0[i] = in1[i] = 1, out[i] = 1 (the consensus term guarantees this).
  - In all other X cases, X propagates per gate semantics.
- No internal state other than the out_q flops.

Decomposition:
- Shared package holds:
  - the NBITS default constant (4);
  - the reset-level constant (RESET_ACTIVE = 1'b0).
- One natural sub-module, mux2_1b_gate: the single-bit gate-level mux (in0, in1, sel_n, sel → out).
  - The top instantiates it NBITS times via generate.
  - The top shares one inverter for sel.
  - The top holds the out_q register bank with asynchronous active-low clear.

Test Plan:
- All zeros: in0 = 0000, in1 = 0000; sel = 0 then sel = 1 → out = 0000 in both cases.
- Complementary patterns, for each pair (0000/1111, 1100/0011, 1010/0101, 1110/0001, 1001/0110, 0111/1000, 0001/1110):
  - sel = 0 → out = in0 (e.g. in0 = 1010, in1 = 0101, sel = 0 → 1010);
  - sel = 1 → out = in1 (→ 0101).
- Edge patterns: in0 = 1111, in1 = 0000, sel = 0 → 1111; same inputs with sel = 1 → 0000.
- Glitch/consensus: in0 = in1 = 1111; toggle sel 0→1→0, also driving sel = X → out stays 1111 throughout.
- Random: 20 iterations of seeded random in0, in1 (4-bit) and sel (1-bit). Check out against the per-bit equation above and against `sel ? in1 : in0`.
- Register/reset:
  - Hold reset = 0 → out_q = 0000, including across clk edges.
  - Release reset with in0 = 0110, sel = 0 → out_q = 0110 after the first rising edge.
  - Set sel = 1 with in1 = 1001 → out_q = 1001 one cycle later.
  - Pull reset low mid-cycle → out_q = 0000 immediately, while out still shows 1001.

Source files
------------

// File: rtl/mux2_4b_gate_pkg.sv
// Shared constants for the gate-level 2:1 mux slice.
package mux2_4b_gate_pkg;

  localparam int unsigned DEF_NBITS = 4;
  localparam logic RESET_ACTIVE = 1'b0;

endpackage

// File: rtl/mux2_1b_gate.sv
// Single-bit 2:1 mux from AND/OR primitives, with the consensus term so a
// select change cannot glitch the output while both data bits are high.
module mux2_1b_gate (
  input  logic in0,
  input  logic in1,
  input  logic sel_n,
  input  logic sel,
  output logic out
);

  logic w_both;
  logic w_pick0;
  logic w_pick1;

  and u_and_both  (w_both,  in0,   in1);
  and u_and_pick0 (w_pick0, sel_n, in0);
  and u_and_pick1 (w_pick1, sel,   in1);
  or  u_or_out    (out, w_both, w_pick0, w_pick1);

endmodule

// File: rtl/mux2_4b_gate.sv
// NBITS-wide gate-level 2:1 mux with a registered copy of the result.
module mux2_4b_gate
  import mux2_4b_gate_pkg::*;
#(
  parameter int unsigned NBITS = DEF_NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  input  logic             sel,
  output logic [NBITS-1:0] out,
  output logic [NBITS-1:0] out_q
);

  logic             w_sel_n;
  logic [NBITS-1:0] r_out_q;

  // One inverter feeds every bit slice.
  not u_inv_sel (w_sel_n, sel);

  for (genvar gi = 0; gi < NBITS; gi++) begin : g_bit
    mux2_1b_gate u_bit (
      .in0   (in0[gi]),
      .in1   (in1[gi]),
      .sel_n (w_sel_n),
      .sel   (sel),
      .out   (out[gi])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ACTIVE) r_out_q <= '0;
    else                       r_out_q <= out;
  end

  assign out_q = r_out_q;

endmodule

// File: tb/tb_mux2_4b_gate.sv
// Scoreboard bench for mux2_4b_gate: stimulus pushes expectations, a monitor checks samples.
module tb_mux2_4b_gate;

  logic       clk;
  logic       reset;
  logic [3:0] in0;
  logic [3:0] in1;
  logic       sel;
  logic [3:0] out;
  logic [3:0] out_q;

  typedef struct {
    string      name;
    logic [3:0] exp_out;
    logic [3:0] exp_q;
    bit         chk_eq;
    logic [3:0] eq_val;
  } item_t;

  item_t sb[$];
  event  sample_ev;
  int    passed = 0;
  int    total  = 0;

  mux2_4b_gate #(.NBITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .in0   (in0),
    .in1   (in1),
    .sel   (sel),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // Monitor: each strobe consumes exactly one expectation.
  initial begin
    item_t it;
    forever begin
      @(sample_ev);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_sample: got out=%b with empty scoreboard", out);
      end else begin
        it = sb.pop_front();
        chk({it.name, "_out"}, out, it.exp_out);
        chk({it.name, "_q"}, out_q, it.exp_q);
        if (it.chk_eq) chk({it.name, "_eq"}, out, it.eq_val);
      end
    end
  end

  // Drive at a falling edge; the rising edge in between lets out_q capture.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic r, input string nm, input bit eq);
    item_t it;
    @(negedge clk);
    in0 = a; in1 = b; sel = s; reset = r;
    it.name = nm;
    if (s === 1'b1)      it.exp_out = b;
    else if (s === 1'b0) it.exp_out = a;
    else                 it.exp_out = (a == b) ? a : 4'bxxxx;
    it.exp_q  = r ? it.exp_out : 4'b0000;
    it.chk_eq = eq;
    it.eq_val = (a & b) | (~{4{s}} & a) | ({4{s}} & b);
    sb.push_back(it);
    #8;
    ->sample_ev;
  endtask

  // Reset dropped between clock edges: out_q clears immediately, out keeps its value.
  task automatic mid_reset(input string nm);
    item_t it;
    #1;
    reset = 1'b0;
    it.name    = nm;
    it.exp_out = (sel === 1'b1) ? in1 : in0;
    it.exp_q   = 4'b0000;
    it.chk_eq  = 1'b0;
    it.eq_val  = 4'b0000;
    sb.push_back(it);
    #1;
    ->sample_ev;
  endtask

  logic [3:0] pa [7];
  logic [3:0] pb [7];

  initial begin
    logic [3:0] ra, rb;
    logic       rs;
    reset = 1'b0; in0 = 4'b0000; in1 = 4'b0000; sel = 1'b0;
    pa = '{4'b0000, 4'b1100, 4'b1010, 4'b1110, 4'b1001, 4'b0111, 4'b0001};
    pb = '{4'b1111, 4'b0011, 4'b0101, 4'b0001, 4'b0110, 4'b1000, 4'b1110};

    apply(4'b1111, 4'b0000, 1'b0, 1'b0, "rst_hold0", 1'b0);
    apply(4'b1010, 4'b0101, 1'b1, 1'b0, "rst_hold1", 1'b0);
    apply(4'b0110, 4'b0000, 1'b0, 1'b1, "rst_release", 1'b0);
    apply(4'b0110, 4'b1001, 1'b1, 1'b1, "sel1_q", 1'b0);
    mid_reset("mid_reset");
    apply(4'b0110, 4'b1001, 1'b1, 1'b0, "rst_hold2", 1'b0);

    apply(4'b0000, 4'b0000, 1'b0, 1'b1, "zeros_s0", 1'b0);
    apply(4'b0000, 4'b0000, 1'b1, 1'b1, "zeros_s1", 1'b0);
    for (int i = 0; i < 7; i++) begin
      apply(pa[i], pb[i], 1'b0, 1'b1, $sformatf("comp%0d_s0", i), 1'b0);
      apply(pa[i], pb[i], 1'b1, 1'b1, $sformatf("comp%0d_s1", i), 1'b0);
    end
    apply(4'b1111, 4'b0000, 1'b0, 1'b1, "edge_s0", 1'b0);
    apply(4'b1111, 4'b0000, 1'b1, 1'b1, "edge_s1", 1'b0);

    apply(4'b1111, 4'b1111, 1'b0, 1'b1, "cons_s0", 1'b0);
    apply(4'b1111, 4'b1111, 1'b1, 1'b1, "cons_s1", 1'b0);
    apply(4'b1111, 4'b1111, 1'bx, 1'b1, "cons_sx", 1'b0);
    apply(4'b1111, 4'b1111, 1'b0, 1'b1, "cons_back", 1'b0);

    void'($urandom(32'd2300));
    for (int i = 0; i < 20; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      apply(ra, rb, rs, 1'b1, $sformatf("rand%0d", i), 1'b1);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) #1;
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending expectations expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion expected finish before 50000");
    $fatal(1);
  end

endmodule
